// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, oversample edge/bit counters, deserializer
// and parity/stop checking, with a glitch filter on the start bit.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          RX_IN,
    input  logic [4:0]                    prescaler,
    input  logic                          PAR_EN,
    input  logic                          PAR_TYP,
    input  logic                          Sampled_bit,
    output logic                          Data_Sample_EN,
    output logic [4:0]                    Edge_Counter,
    output logic [$clog2(DATA_WIDTH):0]   Bit_Counter,
    output logic [DATA_WIDTH-1:0]         P_DATA,
    output logic                          data_valid,
    output logic                          par_err,
    output logic                          stp_err
);

    localparam int BCW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [4:0]            edge_q, edge_d;
    logic [4:0]            p_q, p_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  bit_r_q, bit_r_d;
    logic                  valid_q, valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic [4:0] dec_edge;
    logic [4:0] last_edge;
    logic       boundary;
    logic       at_dec;

    // Decision edge is the first edge where the sampler's 3-sample vote is complete.
    assign dec_edge  = (p_q == 5'd4) ? 5'd2 : ((p_q >> 1) + 5'd2);
    assign last_edge = p_q - 5'd1;
    assign boundary  = (edge_q == last_edge);
    assign at_dec    = (edge_q == dec_edge);

    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        p_d       = p_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pdata_d   = pdata_q;
        bit_r_d   = bit_r_q;
        valid_d   = 1'b0;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;

        if (state_q != IDLE) begin
            edge_d = boundary ? 5'd0 : edge_q + 5'd1;
            if (at_dec) bit_r_d = Sampled_bit;
        end

        case (state_q)
            IDLE: begin
                edge_d    = 5'd0;
                bit_cnt_d = '0;
                if (!RX_IN) begin
                    state_d   = START;
                    p_d       = prescaler;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                end
            end
            START: begin
                if (at_dec && Sampled_bit) begin
                    state_d = IDLE;
                    edge_d  = 5'd0;
                end else if (boundary) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (boundary) begin
                    shift_d = {bit_r_q, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = PAR_EN ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (boundary) begin
                    par_err_d = bit_r_q ^ (^shift_q) ^ PAR_TYP;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (boundary) begin
                    stp_err_d = ~bit_r_q;
                    if (bit_r_q && !par_err_q) begin
                        pdata_d = shift_q;
                        valid_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            edge_q    <= '0;
            p_q       <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            pdata_q   <= '0;
            bit_r_q   <= 1'b0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            p_q       <= p_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            pdata_q   <= pdata_d;
            bit_r_q   <= bit_r_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
        end
    end

    assign Data_Sample_EN = (state_q != IDLE);
    assign Edge_Counter   = edge_q;
    assign Bit_Counter    = bit_cnt_q;
    assign P_DATA         = pdata_q;
    assign data_valid     = valid_q;
    assign par_err        = par_err_q;
    assign stp_err        = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: table of frames plus hand sequences for false start,
// back-to-back frames and mid-frame reset; delivered bytes checked via a scoreboard.
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [4:0] prescaler = 5'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       Sampled_bit;
    logic       Data_Sample_EN;
    logic [4:0] Edge_Counter;
    logic [3:0] Bit_Counter;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    // Sampling stage modelled as one register on the line.
    logic samp_q = 1'b1;
    always @(posedge CLK) samp_q <= RX_IN;
    assign Sampled_bit = samp_q;

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .prescaler(prescaler),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Sampled_bit(Sampled_bit),
        .Data_Sample_EN(Data_Sample_EN), .Edge_Counter(Edge_Counter),
        .Bit_Counter(Bit_Counter), .P_DATA(P_DATA), .data_valid(data_valid),
        .par_err(par_err), .stp_err(stp_err)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int n_valid = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RST === 1'b1 && data_valid === 1'b1) begin
            n_valid++;
            chk("scoreboard_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                chk("p_data_at_valid", P_DATA, exp_v);
                chk("flags_at_valid", {par_err, stp_err}, 0);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int p);
        RX_IN = b;
        repeat (p) tick();
    endtask

    task automatic send_frame(input logic [4:0] p, input logic pe, input logic pt,
                              input logic [7:0] data, input logic pb, input logic sb);
        prescaler = p;
        PAR_EN    = pe;
        PAR_TYP   = pt;
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(data[i], p);
        if (pe) drive_bit(pb, p);
        drive_bit(sb, p);
        RX_IN = 1'b1;
    endtask

    typedef struct {
        logic [4:0] p;
        logic       pe;
        logic       pt;
        logic [7:0] data;
        logic       pb;
        logic       sb;
        logic       exp_valid;
        logic [7:0] exp_pdata;
        logic       exp_pe;
        logic       exp_se;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int v0;

        //             p    pe    pt    data   pb    sb    vld   pdata  perr  serr
        vecs[0] = '{5'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{5'd16, 1'b1, 1'b0, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[2] = '{5'd16, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1, 1'b0, 8'h07, 1'b1, 1'b0};
        vecs[3] = '{5'd4,  1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h07, 1'b0, 1'b1};
        vecs[4] = '{5'd4,  1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[5] = '{5'd8,  1'b1, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[6] = '{5'd8,  1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0};
        vecs[7] = '{5'd16, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

        // Reset state
        #12;
        chk("rst_en", Data_Sample_EN, 0);
        chk("rst_edge", Edge_Counter, 0);
        chk("rst_bitcnt", Bit_Counter, 0);
        chk("rst_pdata", P_DATA, 0);
        chk("rst_flags", {data_valid, par_err, stp_err}, 0);
        tick();
        RST = 1'b1;
        repeat (4) tick();
        chk("idle_en", Data_Sample_EN, 0);

        for (int i = 0; i < 8; i++) begin
            v0 = n_valid;
            if (vecs[i].exp_valid) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].p, vecs[i].pe, vecs[i].pt, vecs[i].data, vecs[i].pb, vecs[i].sb);
            repeat (3 * int'(vecs[i].p)) tick();
            chk($sformatf("row%0d_valid_count", i), n_valid - v0, 32'(vecs[i].exp_valid));
            chk($sformatf("row%0d_pdata", i), P_DATA, vecs[i].exp_pdata);
            chk($sformatf("row%0d_par_err", i), par_err, vecs[i].exp_pe);
            chk($sformatf("row%0d_stp_err", i), stp_err, vecs[i].exp_se);
            chk($sformatf("row%0d_idle_en", i), Data_Sample_EN, 0);
        end

        // False start: two low cycles, then high
        v0 = n_valid;
        prescaler = 5'd8;
        PAR_EN = 1'b0;
        RX_IN = 1'b0;
        tick();
        tick();
        RX_IN = 1'b1;
        chk("fs_en_high", Data_Sample_EN, 1);
        chk("fs_edge", Edge_Counter, 1);
        repeat (12) tick();
        chk("fs_en_low", Data_Sample_EN, 0);
        chk("fs_edge_idle", Edge_Counter, 0);
        chk("fs_flags", {par_err, stp_err}, 0);
        chk("fs_no_valid", n_valid - v0, 0);
        chk("fs_pdata", P_DATA, 8'hFF);

        // Back-to-back frames, no idle gap on the line
        v0 = n_valid;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        send_frame(5'd8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1);
        send_frame(5'd8, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1);
        repeat (24) tick();
        chk("b2b_valid_count", n_valid - v0, 2);
        chk("b2b_pdata", P_DATA, 8'hAA);
        chk("b2b_flags", {par_err, stp_err}, 0);

        // Reset during data bit 3
        prescaler = 5'd8;
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 8);
        RX_IN = 1'b0;
        repeat (3) tick();
        chk("mid_bitcnt", Bit_Counter, 3);
        chk("mid_en", Data_Sample_EN, 1);
        #2 RST = 1'b0;
        #1;
        chk("arst_en", Data_Sample_EN, 0);
        chk("arst_edge", Edge_Counter, 0);
        chk("arst_bitcnt", Bit_Counter, 0);
        chk("arst_pdata", P_DATA, 0);
        chk("arst_flags", {data_valid, par_err, stp_err}, 0);
        RX_IN = 1'b1;
        repeat (3) tick();
        RST = 1'b1;
        repeat (10) tick();
        v0 = n_valid;
        exp_q.push_back(8'hF0);
        send_frame(5'd8, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b1);
        repeat (24) tick();
        chk("post_rst_valid_count", n_valid - v0, 1);
        chk("post_rst_pdata", P_DATA, 8'hF0);

        chk("scoreboard_drained", exp_q.size(), 0);
        chk("total_valid", n_valid, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-path controller for the UART RX: frame FSM, per-bit edge counter, data-bit counter, deserializer, and parity/stop checking in one block.
- Drives Edge_Counter and Data_Sample_EN to the data sampling stage.
- Consumes that stage's majority-voted Sampled_bit.
- Presents the completed byte and error flags to the system side.

Parameters:
DATA_WIDTH, 8, number of data bits per frame, sent LSB first.

Ports:
CLK  input  1  system clock, oversampling rate.
RST  input  1  asynchronous active-low reset.
RX_IN  input  1  serial line, idle high; already synchronised upstream.
prescaler  input  5  oversampling ratio; legal values 4, 8, 16.
PAR_EN  input  1  1 = frame carries a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
Sampled_bit  input  1  voted bit value from the data sampling stage.
Data_Sample_EN  output  1  enables the sampling stage; high in every state except IDLE.
Edge_Counter  output  5  oversample edge index within the current bit, 0..P-1.
Bit_Counter  output  4  data bit index within DATA state, 0..DATA_WIDTH-1.
P_DATA  output  DATA_WIDTH  last good received byte.
data_valid  output  1  one-cycle pulse when P_DATA is updated.
par_err  output  1  parity mismatch on the last frame.
stp_err  output  1  stop bit sampled low on the last frame.

Behaviour:
- Reset: state=IDLE. Edge_Counter, Bit_Counter, P_DATA, shift register, data_valid, par_err, stp_err and Data_Sample_EN all 0.
- P is the prescaler value latched on IDLE->START. Prescaler changes mid-frame are ignored.
- Decision edge D: D = 2 when P = 4; D = P/2 + 2 otherwise. This is the first edge at which the sampler's three-sample vote is complete.
- At Edge_Counter == D, Sampled_bit is registered into bit_r.
- Edge_Counter:
  - Held at 0 in IDLE.
  - Counts 0..P-1 and wraps to 0 while in any non-IDLE state.
  - The bit boundary is the cycle where Edge_Counter == P-1; all state transitions except the START abort occur on this cycle.
- IDLE:
  - RX_IN == 0 sampled -> START next cycle, with Edge_Counter = 0.
  - On entry to START, par_err and stp_err clear.
- START (false-start filter):
  - At Edge_Counter == D, if Sampled_bit == 1: glitch -> IDLE next cycle, with no output and no error flags.
  - Otherwise, at the boundary -> DATA with Bit_Counter = 0.
- DATA:
  - At the boundary, bit_r shifts into the shift register from the MSB side, so that the first received bit ends at P_DATA[0].
  - Bit_Counter increments.
  - When Bit_Counter == DATA_WIDTH-1 at the boundary: -> PARITY if PAR_EN, else -> STOP. Bit_Counter returns to 0.
- PARITY:
  - Expected value = XOR of shift register, inverted when PAR_TYP = 1.
  - At the boundary, par_err <= (bit_r != expected); -> STOP.
- STOP:
  - At the boundary, stp_err <= ~bit_r.
  - If the stop bit is high and par_err == 0: P_DATA <= shift register and data_valid = 1 for exactly one cycle.
  - Otherwise P_DATA holds.
  - -> IDLE in all cases.
- Flag persistence: par_err and stp_err hold until the next START entry.
- Back-to-back frames: IDLE is re-entered for at least one cycle. A start bit whose falling edge fell inside the last stop-bit window is detected on that first IDLE cycle.
- PAR_EN and PAR_TYP are sampled at the point of use, and are stable per frame by system rule.
- Asynchronous reset mid-frame aborts immediately: all outputs return to reset values and no data_valid is produced.
- Arithmetic: Edge_Counter, D and P-1 are computed at 5 bits with no overflow for legal P. Bit_Counter is ceil(log2(DATA_WIDTH))+1 bits, fixed at 4 for the default.

Test Plan:
- Good frame: P=8, PAR_EN=0, byte 0xA5 sent LSB first with ideal bit timing, Sampled_bit model = RX_IN at decision edge -> data_valid pulses once at the last stop-bit edge, P_DATA = 0xA5, errors 0.
- Parity: P=16, PAR_EN=1, PAR_TYP=0, byte 0x07 with parity bit 1 -> valid, P_DATA = 0x07. Same frame with parity bit 0 -> par_err = 1, no data_valid, P_DATA unchanged.
- Stop error: P=4, byte 0x3C, stop bit driven 0 -> stp_err = 1, no data_valid; next good frame 0x11 clears stp_err at START and delivers 0x11.
- False start: P=8, RX_IN low for 2 cycles then high -> FSM returns to IDLE, Data_Sample_EN falls, no flags or valid.
- Back-to-back: P=8, frames 0x55 then 0xAA with zero idle gap -> two data_valid pulses, P_DATA 0x55 then 0xAA, no errors.
- Reset: assert RST low during data bit 3 -> all outputs 0 asynchronously; after release, a clean frame 0xF0 is received correctly.
